reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the write port of the 4-bit register bank (NUM_REGS enable-DFF registers, common D bus) between two requesters: ALU writeback (req0) and load unit (req1).
- Arbitration is round-robin with valid/ready handshakes.
- A requester may optionally lock the port for a bounded burst.
- Drives the registers' one-hot enable lines and the shared data bus.

Parameters:
- NUM_REGS, 4, number of registers in the bank (2..16).
- ADDR_W, 2, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- DATA_W, 4, register data width.
- LOCK_MAX, 3, maximum consecutive locked grants to one requester before forced release (>=1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_W  requester 0 target register.
- req0_data  in  DATA_W  requester 0 write data.
- req0_lock  in  1  requester 0 requests to keep ownership after this transfer.
- req0_ready  out  1  requester 0 transfer accepted this cycle (combinational).
- req1_valid, req1_addr, req1_data, req1_lock, req1_ready  as for requester 0.
- wr_en  out  NUM_REGS  one-hot register enables (registered).
- wr_data  out  DATA_W  shared register D bus (registered).
- grant_owner  out  1  requester whose write is currently on wr_en/wr_data (registered).
- busy  out  1  a write is being presented this cycle (registered, = |wr_en).

Behaviour:
- Reset (reset=0, asynchronous, immediate) sets:
  - state=IDLE, rr_ptr=0 (req0 has priority), lock_cnt=0;
  - wr_en=0, wr_data=0, grant_owner=0, busy=0.
- Transfer: requester i's transfer occurs when reqi_valid & reqi_ready are both high at a rising edge. At most one ready is high in any cycle.
- Latency: a transfer accepted at edge N drives wr_en/wr_data/grant_owner/busy from edge N until edge N+1. The register bank captures the data at edge N+1. Throughput is one write per cycle.
- A cycle with no transfer gives wr_en=0 at the next edge. wr_data holds its last value.
- States: IDLE, OWN0, OWN1.
- Arbitration in IDLE, or in OWNi when reqi_valid=0:
  - only one valid: grant it;
  - both valid: grant the requester rr_ptr points to.
- In OWNi with reqi_valid=1: grant i only; the other requester's ready=0.
- rr_ptr update: after any transfer by i, rr_ptr <= other requester. Exception: a transfer that leaves the state in OWNi keeps rr_ptr unchanged.
- State transitions after a transfer by i:
  - reqi_lock=1 and lock_cnt < LOCK_MAX-1 -> OWNi, lock_cnt++;
  - otherwise (lock=0 or limit reached) -> IDLE, lock_cnt=0, rr_ptr <= other.
- No transfer in a cycle -> IDLE, lock_cnt=0. A lock owner that drops valid loses ownership.
- Address >= NUM_REGS: the transfer is still accepted (ready=1), but wr_en=0 and busy=0. The write is silently dropped and still counts toward rr/lock.
- Write collisions on the same register are impossible by construction, since there is one grant per cycle.
- Reset asserted mid-burst: ownership and any write in flight are abandoned immediately. wr_en=0 asynchronously.
- Inputs are sampled only when valid=1; addr/data/lock are don't-care otherwise.

Optional Feature:
- Macro: REG_WRITE_ARB_PERF_EN.
- Defined:
  - adds outputs grant_cnt0 and grant_cnt1 (8 bits each);
  - each counts accepted transfers per requester and saturates at 255;
  - both are cleared by reset.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package (reg_arb_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2;
  - default NUM_REGS/ADDR_W/DATA_W constants;
  - requester index constants REQ_ALU=0, REQ_LOAD=1.
- One sub-module: onehot_decoder (ADDR_W -> NUM_REGS one-hot, all-zero for out-of-range), used to build wr_en.

Test Plan:
- Reset release, then req0 valid addr=2 data=4'hA -> req0_ready=1; next cycle wr_en=4'b0100, wr_data=4'hA, grant_owner=0, busy=1; following cycle wr_en=0.
- Both valid every cycle, lock=0, after reset -> grants alternate req0,req1,req0,req1; wr_en follows the addresses, one cycle late.
- req1 lock=1 continuously, req0 valid, LOCK_MAX=3 -> req1 granted 3 consecutive cycles, then req0 granted, then req1.
- req0 lock=1 granted, then req0_valid drops while req1 valid -> req1 granted in that same cycle; state returns to IDLE.
- Transfer with addr=3 in a NUM_REGS=3 build -> ready=1, wr_en=0, busy=0; rr_ptr still advances.
- reset pulsed low between clock edges during a locked burst -> wr_en/busy/grant_owner go to 0 immediately; the first grant after release goes to req0. With REG_WRITE_ARB_PERF_EN defined, counters also read 0.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the register-bank write arbiter.
// Package name reg_arb_pkg; imported by the arbiter and its decoder.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_ADDR_W   = 2;
  localparam int DEF_DATA_W   = 4;
  localparam int DEF_LOCK_MAX = 3;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

endpackage

// File: rtl/reg_write_arbiter_decoder.sv
// Address to one-hot register enable decoder.
// Addresses at or above NUM_REGS decode to all zeros.
module onehot_decoder
  import reg_arb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin, lockable arbiter for the register-bank write port.
// Define REG_WRITE_ARB_PERF_EN to add per-requester grant counters.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_lock,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_lock,
  output logic              req1_ready,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              grant_owner,
  output logic              busy
`ifdef REG_WRITE_ARB_PERF_EN
  ,
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1
`endif
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  state_t          state;
  logic            rr_ptr;
  logic [CW-1:0]   lock_cnt;

  logic            hold0;
  logic            hold1;
  logic            g0;
  logic            g1;
  logic            take;
  logic            glock;
  logic            keep;
  logic [CW-1:0]   base_cnt;
  logic [ADDR_W-1:0] gaddr;
  logic [DATA_W-1:0] gdata;
  logic [NUM_REGS-1:0] dec;

  assign hold0 = (state == ST_OWN0) && req0_valid;
  assign hold1 = (state == ST_OWN1) && req1_valid;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (1'b1)
      hold0: g0 = 1'b1;
      hold1: g1 = 1'b1;
      default: begin
        g0 = req0_valid & (~req1_valid | ~rr_ptr);
        g1 = req1_valid & (~req0_valid | rr_ptr);
      end
    endcase
  end

  assign req0_ready = g0;
  assign req1_ready = g1;
  assign take       = g0 | g1;
  assign gaddr      = g1 ? req1_addr : req0_addr;
  assign gdata      = g1 ? req1_data : req0_data;
  assign glock      = g1 ? req1_lock : req0_lock;

  // A new owner starts its burst count from zero
  assign base_cnt = (hold0 | hold1) ? lock_cnt : '0;
  assign keep     = glock && (int'(base_cnt) < LOCK_MAX - 1);

  onehot_decoder #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_dec (
    .addr   (gaddr),
    .onehot (dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      lock_cnt    <= '0;
      wr_en       <= '0;
      wr_data     <= '0;
      grant_owner <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wr_en <= take ? dec : '0;
      busy  <= take & (|dec);
      if (take) begin
        wr_data     <= gdata;
        grant_owner <= g1 ? 1'(REQ_LOAD) : 1'(REQ_ALU);
      end
      if (take && keep) begin
        state    <= g1 ? ST_OWN1 : ST_OWN0;
        lock_cnt <= base_cnt + CW'(1);
      end else begin
        state    <= ST_IDLE;
        lock_cnt <= '0;
        if (take) rr_ptr <= ~g1;
      end
    end
  end

`ifdef REG_WRITE_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (g0 && grant_cnt0 != 8'hFF) grant_cnt0 <= grant_cnt0 + 8'd1;
      if (g1 && grant_cnt1 != 8'hFF) grant_cnt1 <= grant_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter (4-reg and 3-reg builds).
// Define REG_WRITE_ARB_PERF_EN to also check the grant counters.
module tb_reg_write_arbiter;

  localparam int LOCK_MAX = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       v0, l0, v1, l1;
  logic [1:0] a0, a1;
  logic [3:0] d0, d1;

  logic       r0, r1, r0b, r1b;
  logic [3:0] wr_en;
  logic [3:0] wr_data, wr_data3;
  logic [2:0] wr_en3;
  logic       owner, owner3, busy, busy3;
`ifdef REG_WRITE_ARB_PERF_EN
  logic [7:0] cnt0, cnt1, cnt0b, cnt1b;
`endif

  always #5 clk = ~clk;

  reg_write_arbiter u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0),
    .req0_lock(l0), .req0_ready(r0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1),
    .req1_lock(l1), .req1_ready(r1),
    .wr_en(wr_en), .wr_data(wr_data),
    .grant_owner(owner), .busy(busy)
`ifdef REG_WRITE_ARB_PERF_EN
    , .grant_cnt0(cnt0), .grant_cnt1(cnt1)
`endif
  );

  reg_write_arbiter #(.NUM_REGS(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0),
    .req0_lock(l0), .req0_ready(r0b),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1),
    .req1_lock(l1), .req1_ready(r1b),
    .wr_en(wr_en3), .wr_data(wr_data3),
    .grant_owner(owner3), .busy(busy3)
`ifdef REG_WRITE_ARB_PERF_EN
    , .grant_cnt0(cnt0b), .grant_cnt1(cnt1b)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the port, burst length, tie winner
  int   m_owner;
  int   m_run;
  int   m_pref;
  logic exp_r0, exp_r1, obs_r0, obs_r1, obs_r0b, obs_r1b;
  logic [3:0] e_en, e_data;
  logic [2:0] e3_en;
  logic e_owner, e_busy, e3_busy;
  int   e_cnt0, e_cnt1;

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_pref = 0;
    e_en = '0; e_data = '0; e_owner = 1'b0; e_busy = 1'b0;
    e3_en = '0; e3_busy = 1'b0;
    e_cnt0 = 0; e_cnt1 = 0;
  endtask

  task automatic apply(input logic iv0, input logic [1:0] ia0,
                       input logic [3:0] id0, input logic il0,
                       input logic iv1, input logic [1:0] ia1,
                       input logic [3:0] id1, input logic il1);
    int g;
    logic [1:0] ga;
    logic gl;
    v0 = iv0; a0 = ia0; d0 = id0; l0 = il0;
    v1 = iv1; a1 = ia1; d1 = id1; l1 = il1;
    if (m_owner == 0 && iv0) g = 0;
    else if (m_owner == 1 && iv1) g = 1;
    else if (iv0 && iv1) g = m_pref;
    else if (iv0) g = 0;
    else if (iv1) g = 1;
    else g = -1;
    exp_r0 = (g == 0);
    exp_r1 = (g == 1);
    #1;
    obs_r0 = r0; obs_r1 = r1; obs_r0b = r0b; obs_r1b = r1b;
    @(posedge clk);
    if (g < 0) begin
      m_owner = -1; m_run = 0;
      e_en = '0; e_busy = 1'b0; e3_en = '0; e3_busy = 1'b0;
    end else begin
      ga = (g == 1) ? ia1 : ia0;
      gl = (g == 1) ? il1 : il0;
      e_data  = (g == 1) ? id1 : id0;
      e_owner = (g == 1);
      e_en    = 4'b0001 << ga;
      e_busy  = 1'b1;
      e3_en   = (ga < 2'd3) ? (3'b001 << ga) : 3'b000;
      e3_busy = (ga < 2'd3);
      if (g == 0 && e_cnt0 < 255) e_cnt0++;
      if (g == 1 && e_cnt1 < 255) e_cnt1++;
      if (g != m_owner) m_run = 0;
      if (gl && m_run + 1 < LOCK_MAX) begin
        m_owner = g; m_run++;
      end else begin
        m_owner = -1; m_run = 0; m_pref = 1 - g;
      end
    end
    #1;
  endtask

  function automatic logic [11:0] got_main();
    return {obs_r1, obs_r0, wr_en, wr_data, owner, busy};
  endfunction

  function automatic logic [11:0] exp_main();
    return {exp_r1, exp_r0, e_en, e_data, e_owner, e_busy};
  endfunction

  function automatic logic [10:0] got_three();
    return {obs_r1b, obs_r0b, wr_en3, busy3, wr_data3, owner3};
  endfunction

  function automatic logic [10:0] exp_three();
    return {exp_r1, exp_r0, e3_en, e3_busy, e_data, e_owner};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    v0 = 0; a0 = 0; d0 = 0; l0 = 0;
    v1 = 0; a1 = 0; d1 = 0; l1 = 0;
    model_reset();
    #12;
    checks++;
    if ({wr_en, wr_data, owner, busy, wr_en3, busy3, r0, r1} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0",
               {wr_en, wr_data, owner, busy, wr_en3, busy3, r0, r1});
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_write();
    apply(1, 2'd2, 4'hA, 0, 0, 2'd0, 4'h0, 0);
    checks++;
    if ({obs_r0, wr_en, wr_data, owner, busy} !== {1'b1, 4'b0100, 4'hA, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL single_write got=%h exp=%h",
               {obs_r0, wr_en, wr_data, owner, busy}, {1'b1, 4'b0100, 4'hA, 1'b0, 1'b1});
    end
    apply(0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0, 0);
    checks++;
    if ({wr_en, wr_data, busy} !== {4'b0000, 4'hA, 1'b0}) begin
      failures++;
      $display("FAIL single_idle got=%h exp=%h", {wr_en, wr_data, busy}, {4'b0000, 4'hA, 1'b0});
    end
  endtask

  task automatic test_alternate();
    logic [1:0] ad0, ad1;
    for (int i = 0; i < 6; i++) begin
      ad0 = 2'($urandom_range(0, 3));
      ad1 = 2'($urandom_range(0, 3));
      apply(1, ad0, 4'($urandom), 0, 1, ad1, 4'($urandom), 0);
      checks++;
      if ({obs_r1, obs_r0, wr_en} !== {(i % 2 == 0), (i % 2 == 1),
                                       4'b0001 << ((i % 2 == 0) ? ad1 : ad0)}) begin
        failures++;
        $display("FAIL alternate[%0d] got=%h", i, {obs_r1, obs_r0, wr_en});
      end
      checks++;
      if (got_main() !== exp_main()) begin
        failures++;
        $display("FAIL alternate_model[%0d] got=%h exp=%h", i, got_main(), exp_main());
      end
    end
  endtask

  task automatic test_lock();
    logic [5:0] seq;
    seq = 6'b110111;
    for (int i = 0; i < 6; i++) begin
      apply(1, 2'd0, 4'h3, 0, 1, 2'd1, 4'($urandom), 1);
      checks++;
      if (obs_r1 !== seq[i] || obs_r0 !== !seq[i]) begin
        failures++;
        $display("FAIL lock_seq[%0d] got r1=%b r0=%b exp r1=%b", i, obs_r1, obs_r0, seq[i]);
      end
      checks++;
      if (got_three() !== exp_three()) begin
        failures++;
        $display("FAIL lock_model[%0d] got=%h exp=%h", i, got_three(), exp_three());
      end
    end
    apply(0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0, 0);
  endtask

  task automatic test_drop();
    apply(1, 2'd1, 4'h5, 1, 0, 2'd0, 4'h0, 0);
    apply(0, 2'd0, 4'h0, 0, 1, 2'd2, 4'h6, 0);
    checks++;
    if ({obs_r1, obs_r0, wr_en, wr_data, owner} !== {2'b10, 4'b0100, 4'h6, 1'b1}) begin
      failures++;
      $display("FAIL drop_handover got=%h", {obs_r1, obs_r0, wr_en, wr_data, owner});
    end
    apply(1, 2'd0, 4'h7, 0, 1, 2'd3, 4'h8, 0);
    checks++;
    if ({obs_r1, obs_r0} !== 2'b01) begin
      failures++;
      $display("FAIL drop_idle got=%b exp=01", {obs_r1, obs_r0});
    end
  endtask

  task automatic test_out_of_range();
    apply(1, 2'd3, 4'h9, 0, 0, 2'd0, 4'h0, 0);
    checks++;
    if ({obs_r0b, wr_en3, busy3, wr_en} !== {1'b1, 3'b000, 1'b0, 4'b1000}) begin
      failures++;
      $display("FAIL oor_drop got=%h exp=%h", {obs_r0b, wr_en3, busy3, wr_en},
               {1'b1, 3'b000, 1'b0, 4'b1000});
    end
    apply(1, 2'd0, 4'h1, 0, 1, 2'd1, 4'h2, 0);
    checks++;
    if ({obs_r1b, obs_r0b, wr_en3} !== {2'b10, 3'b010}) begin
      failures++;
      $display("FAIL oor_rr got=%h exp=%h", {obs_r1b, obs_r0b, wr_en3}, {2'b10, 3'b010});
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), 1'($urandom));
      checks++;
      if (got_main() !== exp_main() || got_three() !== exp_three()) begin
        failures++;
        bad++;
        if (bad < 10)
          $display("FAIL random[%0d] got=%h/%h exp=%h/%h", i,
                   got_main(), got_three(), exp_main(), exp_three());
      end
    end
`ifdef REG_WRITE_ARB_PERF_EN
    checks++;
    if ({cnt0, cnt1, cnt0b, cnt1b} !== {8'(e_cnt0), 8'(e_cnt1), 8'(e_cnt0), 8'(e_cnt1)}) begin
      failures++;
      $display("FAIL perf_counts got=%h exp=%0d/%0d", {cnt0, cnt1, cnt0b, cnt1b}, e_cnt0, e_cnt1);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    apply(1, 2'd1, 4'h4, 0, 1, 2'd1, 4'hC, 1);
    apply(1, 2'd1, 4'h4, 0, 1, 2'd1, 4'hC, 1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL burst_active got busy=%b exp=1", busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({wr_en, busy, owner, wr_en3, busy3} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", {wr_en, busy, owner, wr_en3, busy3});
    end
`ifdef REG_WRITE_ARB_PERF_EN
    checks++;
    if ({cnt0, cnt1} !== 16'h0) begin
      failures++;
      $display("FAIL perf_reset got=%h exp=0", {cnt0, cnt1});
    end
`endif
    #1;
    reset = 1'b1;
    model_reset();
    apply(1, 2'd3, 4'hE, 0, 1, 2'd2, 4'hF, 0);
    checks++;
    if ({obs_r1, obs_r0, wr_en, owner} !== {2'b01, 4'b1000, 1'b0}) begin
      failures++;
      $display("FAIL first_after_reset got=%h", {obs_r1, obs_r0, wr_en, owner});
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_alternate();
    test_lock();
    test_drop();
    test_out_of_range();
    test_random();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
